// File: rtl/bus_pkg.sv
// Shared bus definitions: response codes and the responder FSM state encoding.
package bus_pkg;

    localparam int unsigned ADDR_W = 32;
    localparam int unsigned DATA_W = 32;

    typedef enum logic {
        RESP_OKAY  = 1'b0,
        RESP_ERROR = 1'b1
    } bus_response;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } responder_state_e;

endpackage

// File: rtl/bus_slave.sv
// Request/response bus between an initiator and a memory responder.
interface bus_slave;
    import bus_pkg::*;

    logic              start;
    logic [ADDR_W-1:0] address;
    logic              write;
    logic [DATA_W-1:0] write_data;
    logic              ready;
    bus_response       response;
    logic [DATA_W-1:0] read_data;

    modport in  (input  start, address, write, write_data,
                 output ready, response, read_data);
    modport out (output start, address, write, write_data,
                 input  ready, response, read_data);
endinterface

// File: rtl/responder_ram.sv
// Single-port word storage: synchronous write, combinational read at the same index.
module responder_ram #(
    parameter int unsigned DEPTH_WORDS = 1024,
    parameter int unsigned IDX_W       = $clog2(DEPTH_WORDS)
) (
    input  logic             clock,
    input  logic             we_i,
    input  logic [IDX_W-1:0] idx_i,
    input  logic [31:0]      wdata_i,
    output logic [31:0]      rdata_o
);

    logic [31:0] mem_q [DEPTH_WORDS];

    always_ff @(posedge clock) begin
        if (we_i) begin
            mem_q[idx_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[idx_i];

endmodule

// File: rtl/memory_responder.sv
// Fixed-latency memory responder on the bus_slave interface.
// Optional build macro RESPONDER_WRITE_PROTECT_EN makes the storage read-only.
module memory_responder
    import bus_pkg::*;
#(
    parameter int unsigned DEPTH_WORDS = 1024,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
    parameter int unsigned LATENCY     = 2
) (
    input logic  clock,
    input logic  reset,
    bus_slave.in bus
);

    localparam int unsigned IDX_W = $clog2(DEPTH_WORDS);
    localparam int unsigned CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;
    localparam logic [32:0] SPAN  = 33'(DEPTH_WORDS) << 2;

    responder_state_e state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic [31:0] addr_q;
    logic        write_q;
    logic [31:0] wdata_q;
    bus_response resp_q;
    logic [31:0] rdata_q;

    logic             ready_c;
    logic             accept_c;
    logic             done_c;
    logic [31:0]      offset_c;
    logic             addr_err_c;
    logic             err_c;
    logic [IDX_W-1:0] idx_c;
    logic             ram_we_c;
    logic [31:0]      ram_rdata_c;

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    state_d = BUSY;
                    cnt_d   = CNT_W'(LATENCY - 1);
                end
            end
            BUSY: begin
                if (cnt_q == '0) begin
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        ready_c  = 1'b0;
        accept_c = 1'b0;
        done_c   = 1'b0;
        if (state_q == IDLE) begin
            ready_c  = !bus.start;
            accept_c = bus.start;
        end else if (cnt_q == '0) begin
            done_c = 1'b1;
        end
    end

    // Request capture happens only on accept; later starts never touch it.
    always_ff @(posedge clock) begin
        if (accept_c) begin
            addr_q  <= bus.address;
            write_q <= bus.write;
            wdata_q <= bus.write_data;
        end
    end

    // 32-bit offset; addresses below the base are rejected explicitly rather than wrapped.
    assign offset_c   = addr_q - BASE_ADDR;
    assign addr_err_c = (addr_q[1:0] != 2'b00) || (addr_q < BASE_ADDR)
                        || ({1'b0, offset_c} >= SPAN);
    assign idx_c      = IDX_W'(offset_c >> 2);

`ifdef RESPONDER_WRITE_PROTECT_EN
    assign err_c = addr_err_c || write_q;
`else
    assign err_c = addr_err_c;
`endif

    assign ram_we_c = done_c && write_q && !err_c && !reset;

    responder_ram #(
        .DEPTH_WORDS (DEPTH_WORDS),
        .IDX_W       (IDX_W)
    ) u_ram (
        .clock   (clock),
        .we_i    (ram_we_c),
        .idx_i   (idx_c),
        .wdata_i (wdata_q),
        .rdata_o (ram_rdata_c)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            resp_q  <= RESP_OKAY;
            rdata_q <= '0;
        end else if (done_c) begin
            if (err_c) begin
                resp_q  <= RESP_ERROR;
                rdata_q <= '0;
            end else begin
                resp_q <= RESP_OKAY;
                if (!write_q) begin
                    rdata_q <= ram_rdata_c;
                end
            end
        end
    end

    assign bus.ready     = ready_c;
    assign bus.response  = resp_q;
    assign bus.read_data = rdata_q;

endmodule

// File: tb/tb_memory_responder.sv
// Randomized bench for memory_responder against a transaction-timing reference model.
module tb_memory_responder;
    import bus_pkg::*;

    localparam int unsigned DEPTH   = 64;
    localparam logic [31:0] BASE    = 32'h0000_0400;
    localparam int unsigned LATENCY = 2;
    localparam longint      SPAN_B  = longint'(DEPTH) * 4;
`ifdef RESPONDER_WRITE_PROTECT_EN
    localparam bit WP = 1'b1;
`else
    localparam bit WP = 1'b0;
`endif

    logic clock;
    logic reset;
    bus_slave bus_if();

    memory_responder #(
        .DEPTH_WORDS (DEPTH),
        .BASE_ADDR   (BASE),
        .LATENCY     (LATENCY)
    ) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus_if)
    );

    always #5 clock = ~clock;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    string phase = "reset";

    // Reference model: a request accepted at the end of cycle n completes at the end of cycle n+LATENCY.
    bit          m_valid = 1'b0;
    bit          m_busy  = 1'b0;
    int          m_done_cyc;
    bit          p_wr;
    logic [31:0] p_addr;
    logic [31:0] p_data;
    logic [31:0] m_mem [DEPTH];
    bus_response exp_resp;
    logic [31:0] exp_rdata;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
        end
    endtask

    function automatic bit addr_bad(input logic [31:0] a);
        longint off;
        off = longint'(a) - longint'(BASE);
        return (a % 4 != 0) || (off < 0) || (off >= SPAN_B);
    endfunction

    task automatic model_edge(input bit st, input bit wr, input logic [31:0] a,
                              input logic [31:0] d, input bit rst);
        int idx;
        if (rst) begin
            m_valid   = 1'b1;
            m_busy    = 1'b0;
            exp_resp  = RESP_OKAY;
            exp_rdata = 32'h0;
        end else if (m_valid) begin
            if (!m_busy) begin
                if (st) begin
                    m_busy     = 1'b1;
                    m_done_cyc = cyc + LATENCY;
                    p_wr   = wr;
                    p_addr = a;
                    p_data = d;
                end
            end else if (cyc == m_done_cyc) begin
                m_busy = 1'b0;
                idx = int'((longint'(p_addr) - longint'(BASE)) / 4);
                if (addr_bad(p_addr) || (p_wr && WP)) begin
                    exp_resp  = RESP_ERROR;
                    exp_rdata = 32'h0;
                end else if (p_wr) begin
                    m_mem[idx] = p_data;
                    exp_resp   = RESP_OKAY;
                end else begin
                    exp_resp  = RESP_OKAY;
                    exp_rdata = m_mem[idx];
                end
            end
        end
    endtask

    // One clock cycle: drive after the rising edge, check at the falling edge, advance the model at the next rising edge.
    task automatic cycle(input bit st, input bit wr, input logic [31:0] a,
                         input logic [31:0] d, input bit rst);
        reset               = rst;
        bus_if.start        = st;
        bus_if.write        = wr;
        bus_if.address      = a;
        bus_if.write_data   = d;
        @(negedge clock);
        if (m_valid) begin
            check_eq($sformatf("%s.ready@%0d", phase, cyc), 32'(bus_if.ready), 32'(!m_busy && !st));
            check_eq($sformatf("%s.resp@%0d", phase, cyc), 32'(bus_if.response), 32'(exp_resp));
            check_eq($sformatf("%s.rdata@%0d", phase, cyc), bus_if.read_data, exp_rdata);
        end
        @(posedge clock);
        model_edge(st, wr, a, d, rst);
        cyc++;
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
    endtask

    // Single request followed by its busy cycles and one observation cycle with start low.
    task automatic req(input bit wr, input logic [31:0] a, input logic [31:0] d);
        cycle(1'b1, wr, a, d, 1'b0);
        idle(LATENCY);
        idle(1);
    endtask

    function automatic logic [31:0] rand_addr();
        logic [31:0] a;
        case ($urandom_range(0, 9))
            0: a = BASE + 32'($urandom_range(0, DEPTH * 4 - 1)) | 32'h1;
            1: a = BASE + 32'(SPAN_B) + 32'($urandom_range(0, 7) * 4);
            2: a = BASE - 32'($urandom_range(1, 8) * 4);
            3: a = $urandom;
            4: a = BASE + 32'(SPAN_B) - 32'h4;
            default: a = BASE + 32'($urandom_range(0, DEPTH - 1) * 4);
        endcase
        return a;
    endfunction

    initial begin
        clock = 1'b0;
        reset = 1'b1;
        bus_if.start = 1'b0;
        bus_if.write = 1'b0;
        bus_if.address = 32'h0;
        bus_if.write_data = 32'h0;
        @(posedge clock);
        #1;

        phase = "reset";
        for (int i = 0; i < 3; i++) cycle(1'b0, 1'b0, 32'h0, 32'h0, 1'b1);
        idle(2);

        // Fill storage with start held high throughout; busy-cycle starts must be ignored.
        phase = "fill";
        for (int i = 0; i < DEPTH; i++) begin
            cycle(1'b1, 1'b1, BASE + 32'(i * 4), $urandom, 1'b0);
            for (int k = 0; k < LATENCY; k++) cycle(1'b1, 1'b0, rand_addr(), $urandom, 1'b0);
        end
        idle(1);

        phase = "wr_rd_10";
        req(1'b1, BASE + 32'h10, 32'hDEAD_BEEF);
        req(1'b0, BASE + 32'h10, 32'h0);

        phase = "bounds";
        req(1'b0, BASE + 32'h13, 32'h0);
        req(1'b0, BASE + 32'(SPAN_B), 32'h0);
        req(1'b0, BASE + 32'(SPAN_B) - 32'h4, 32'h0);
        req(1'b0, BASE - 32'h4, 32'h0);
        req(1'b1, BASE + 32'(SPAN_B), 32'h1234_5678);
        req(1'b0, BASE, 32'h0);

        phase = "ignore_busy";
        cycle(1'b1, 1'b0, BASE + 32'h8, 32'h0, 1'b0);
        cycle(1'b1, 1'b1, BASE + 32'h8, 32'hFFFF_FFFF, 1'b0);
        cycle(1'b1, 1'b0, BASE + 32'h30, 32'h0, 1'b0);
        idle(3);
        req(1'b0, BASE + 32'h8, 32'h0);

        phase = "reset_busy";
        cycle(1'b1, 1'b1, BASE + 32'h20, 32'h55, 1'b0);
        cycle(1'b0, 1'b0, 32'h0, 32'h0, 1'b1);
        idle(3);
        req(1'b0, BASE + 32'h20, 32'h0);

        phase = "write_prot";
        req(1'b1, BASE, 32'h1);
        req(1'b0, BASE, 32'h0);

        phase = "random";
        for (int i = 0; i < 3000; i++) begin
            cycle(($urandom_range(0, 2) != 0), $urandom_range(0, 1) == 1, rand_addr(), $urandom,
                  ($urandom_range(0, 99) == 0));
        end
        idle(LATENCY + 1);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
